// File: rtl/gauss3x3_mac.sv
// gauss3x3_mac: serial 3x3 Gaussian multiply-accumulate, one tap per cycle.
// Kernel 1 2 1 / 2 4 2 / 1 2 1 as shifts, result >> NORM_SHIFT.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      window handshake, in_window = p8..p0 (p0 in LSBs)
//   out_valid/out_ready    pixel handshake, out_pixel = filtered pixel
//   busy                   high while accumulating or holding a result
//
// Build option: define GAUSS_EXACT_ADD_EN to replace the approximate
// aba_adder with an exact ACC_W-bit adder. Timing and ports are unchanged.

module aba_adder #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o
);

`ifdef GAUSS_EXACT_ADD_EN

    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i};

`else

    // Low nibble is not summed: it is filled with a[3], and a[3] is
    // folded into the upper sum as a carry-in approximation.
    localparam int LO = 4;
    localparam int HW = WIDTH - LO;

    logic [HW:0]   hi;
    logic [LO-1:0] unused_b_lo;

    assign hi = {1'b0, a_i[WIDTH-1:LO]}
              + {1'b0, b_i[WIDTH-1:LO]}
              + {{HW{1'b0}}, a_i[LO-1]};

    assign s_o         = {hi[HW-1:0], {LO{a_i[LO-1]}}};
    assign cout_o      = hi[HW];
    assign unused_b_lo = b_i[LO-1:0];

`endif

endmodule

module gauss3x3_mac #(
    parameter int PIX_W      = 8,
    parameter int ACC_W      = 12,
    parameter int NORM_SHIFT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9*PIX_W-1:0] in_window,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIX_W-1:0]   out_pixel,
    output logic               busy
);

    localparam int TAPS = 9;
    localparam int KW   = 4;
    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [9*PIX_W-1:0] win_q, win_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [KW-1:0]      k_q, k_d;
    logic [PIX_W-1:0]   pix_q, pix_d;

    logic [PIX_W-1:0] tap;
    logic [1:0]       wsh;
    logic [ACC_W-1:0] b_opnd;
    logic [ACC_W-1:0] sum;
    logic             unused_cout;
    logic             accept;
    logic             last_tap;

    assign accept   = in_valid && in_ready;
    assign last_tap = (k_q == K_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (last_tap) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE:  in_ready = 1'b1;
            S_ACCUM: busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b1;
        endcase
    end

    assign out_pixel = pix_q;

    // ---------------- tap select and weight ----------------
    // Shift per tap: centre x4, edges x2, corners x1.
    always_comb begin
        tap = '0;
        wsh = 2'd0;
        unique case (k_q)
            4'd0: tap = win_q[0*PIX_W +: PIX_W];
            4'd1: begin
                tap = win_q[1*PIX_W +: PIX_W];
                wsh = 2'd1;
            end
            4'd2: tap = win_q[2*PIX_W +: PIX_W];
            4'd3: begin
                tap = win_q[3*PIX_W +: PIX_W];
                wsh = 2'd1;
            end
            4'd4: begin
                tap = win_q[4*PIX_W +: PIX_W];
                wsh = 2'd2;
            end
            4'd5: begin
                tap = win_q[5*PIX_W +: PIX_W];
                wsh = 2'd1;
            end
            4'd6: tap = win_q[6*PIX_W +: PIX_W];
            4'd7: begin
                tap = win_q[7*PIX_W +: PIX_W];
                wsh = 2'd1;
            end
            4'd8: tap = win_q[8*PIX_W +: PIX_W];
            default: begin
                tap = '0;
                wsh = 2'd0;
            end
        endcase
    end

    assign b_opnd = {{(ACC_W-PIX_W){1'b0}}, tap} << wsh;

    // Accumulator is always the a operand; carry out cannot occur
    // for 8-bit taps (max weighted sum 4080).
    aba_adder #(
        .WIDTH (ACC_W)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (b_opnd),
        .s_o    (sum),
        .cout_o (unused_cout)
    );

    // ---------------- datapath next state ----------------
    always_comb begin
        win_d = win_q;
        acc_d = acc_q;
        k_d   = k_q;
        pix_d = pix_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    win_d = in_window;
                    acc_d = '0;
                    k_d   = '0;
                end
            end
            S_ACCUM: begin
                acc_d = sum;
                k_d   = k_q + 4'd1;
                // Result register loads with the final sum, so it is
                // valid on the first DONE cycle and held afterwards.
                if (last_tap) begin
                    pix_d = sum[NORM_SHIFT+PIX_W-1:NORM_SHIFT];
                end
            end
            default: ;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q <= '0;
            acc_q <= '0;
            k_q   <= '0;
            pix_q <= '0;
        end else begin
            win_q <= win_d;
            acc_q <= acc_d;
            k_q   <= k_d;
            pix_q <= pix_d;
        end
    end

endmodule

// File: tb/tb_gauss3x3_mac.sv
// tb_gauss3x3_mac: directed, table-driven bench for gauss3x3_mac.
// Expected pixels are hand-computed for the selected adder build.

module tb_gauss3x3_mac;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_window;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gauss3x3_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_window (in_window),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .busy      (busy)
    );

    typedef struct {
        string       name;
        logic [71:0] win;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[10];

`ifdef GAUSS_EXACT_ADD_EN
    localparam logic [7:0] E_ALL255  = 8'd255;
    localparam logic [7:0] E_ALL8    = 8'd8;
    localparam logic [7:0] E_CORNERS = 8'd63;
`else
    localparam logic [7:0] E_ALL255  = 8'd247;
    localparam logic [7:0] E_ALL8    = 8'd6;
    localparam logic [7:0] E_CORNERS = 8'd60;
`endif

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] win9(
        input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2,
        input logic [7:0] p3, input logic [7:0] p4, input logic [7:0] p5,
        input logic [7:0] p6, input logic [7:0] p7, input logic [7:0] p8);
        return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
    endfunction

    function automatic logic [71:0] fill(input logic [7:0] v);
        return {9{v}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with latency and result checks.
    task automatic run_window(input string name, input logic [71:0] w,
                              input logic [7:0] exp);
        int cyc;
        int wc;
        wc = 0;
        while (!in_ready && wc < 30) begin
            tick();
            wc++;
        end
        chk({name, " ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_window = w;
        tick();
        in_valid  = 1'b0;
        in_window = ~w;
        chk({name, " busy"}, 32'(busy), 32'd1);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd10);
        chk({name, " pixel"}, 32'(out_pixel), 32'(exp));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({name, " ready_back"}, 32'(in_ready), 32'd1);
        chk({name, " pixel_hold"}, 32'(out_pixel), 32'(exp));
    endtask

    initial begin
        int wc;
        int n_acc;
        int n_out;
        int acc_cyc[2];
        int out_cyc[2];
        logic [7:0] out_val[2];
        logic hs_in;
        logic hs_out;
        logic seen;

        vecs[0] = '{"zeros",    fill(8'd0),   8'd0};
        vecs[1] = '{"all255",   fill(8'd255), E_ALL255};
        vecs[2] = '{"centre100",
                    win9(0, 0, 0, 0, 100, 0, 0, 0, 0), 8'd25};
        vecs[3] = '{"p0_16",
                    win9(16, 0, 0, 0, 0, 0, 0, 0, 0), 8'd1};
        vecs[4] = '{"all16",    fill(8'd16),  8'd16};
        vecs[5] = '{"p0_15",
                    win9(15, 0, 0, 0, 0, 0, 0, 0, 0), 8'd0};
        vecs[6] = '{"all8",     fill(8'd8),   E_ALL8};
        vecs[7] = '{"centre255",
                    win9(0, 0, 0, 0, 255, 0, 0, 0, 0), 8'd63};
        vecs[8] = '{"edges200",
                    win9(0, 200, 0, 200, 0, 200, 0, 200, 0), 8'd100};
        vecs[9] = '{"corners255",
                    win9(255, 0, 255, 0, 0, 0, 255, 0, 255), E_CORNERS};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_window = '0;
        #12;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_pixel", 32'(out_pixel), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_window(vecs[i].name, vecs[i].win, vecs[i].exp);
        end

        // Backpressure: hold DONE for 5 cycles, offer another window.
        in_valid  = 1'b1;
        in_window = fill(8'd255);
        tick();
        in_window = fill(8'd0);
        wc = 0;
        while (!out_valid && wc < 20) begin
            tick();
            wc++;
        end
        chk("bp reach_done", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("bp valid", 32'(out_valid), 32'd1);
            chk("bp pixel", 32'(out_pixel), 32'(E_ALL255));
            chk("bp in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        chk("bp valid_drop", 32'(out_valid), 32'd0);
        chk("bp ready_back", 32'(in_ready), 32'd1);
        chk("bp pixel_hold", 32'(out_pixel), 32'(E_ALL255));
        tick();
        chk("bp no_accept", 32'(busy), 32'd0);

        // Back-to-back with in_valid held high.
        n_acc     = 0;
        n_out     = 0;
        acc_cyc   = '{-1, -1};
        out_cyc   = '{-1, -1};
        out_val   = '{8'd0, 8'd0};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_window = fill(8'd0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out) begin
                if (n_out < 2) begin
                    out_cyc[n_out] = cyc;
                    out_val[n_out] = out_pixel;
                end
                n_out++;
            end
            if (hs_in) begin
                if (n_acc < 2) acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
            if (hs_in) begin
                if (n_acc == 1) in_window = fill(8'd255);
                else in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b accepts", 32'(n_acc), 32'd2);
        chk("b2b outputs", 32'(n_out), 32'd2);
        chk("b2b out0_cyc", 32'(out_cyc[0]), 32'd10);
        chk("b2b out0_val", 32'(out_val[0]), 32'd0);
        chk("b2b acc1_cyc", 32'(acc_cyc[1]), 32'd11);
        chk("b2b out1_cyc", 32'(out_cyc[1]), 32'd21);
        chk("b2b out1_val", 32'(out_val[1]), 32'(E_ALL255));

        // Reset during ACCUM at k=4.
        in_valid  = 1'b1;
        in_window = fill(8'd255);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        chk("mid busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid rst in_ready", 32'(in_ready), 32'd1);
        chk("mid rst out_valid", 32'(out_valid), 32'd0);
        chk("mid rst out_pixel", 32'(out_pixel), 32'd0);
        chk("mid rst busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("mid no_output", 32'(seen), 32'd0);
        run_window("post_rst", win9(0, 0, 0, 0, 100, 0, 0, 0, 0), 8'd25);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
